// File: rtl/mux_n_to_1_arb.sv
// CH-to-1 multiplexer with fixed-select or round-robin arbitration feeding
// a single registered output word with valid/ready handshaking.
module mux_n_to_1_arb #(
    parameter  int unsigned n  = 5,
    parameter  int unsigned CH = 4,
    localparam int unsigned SW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [CH*n-1:0] in_data,
    input  logic [CH-1:0]   in_valid,
    output logic [CH-1:0]   in_ready,
    input  logic [SW-1:0]   sel,
    input  logic            mode,
    output logic [n-1:0]    out_data,
    output logic [SW-1:0]   out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [n-1:0]  out_data_q,  out_data_d;
    logic [SW-1:0] out_ch_q,    out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] last_q,      last_d;

    logic          load_en;
    logic          found;
    logic          grant;
    logic [SW-1:0] gnt_idx;
    logic [SW-1:0] rr_idx;
    logic [n-1:0]  gnt_data;

    assign load_en = !out_valid_q || out_ready;

    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        rr_idx   = '0;
        gnt_data = '0;
        in_ready = '0;
        if (!mode) begin
            // sel values of CH or above never match a channel, so they never grant
            for (int unsigned i = 0; i < CH; i++) begin
                if (32'(sel) == i && in_valid[i]) begin
                    found   = 1'b1;
                    gnt_idx = SW'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= CH; k++) begin
                rr_idx = SW'((32'(last_q) + k) % CH);
                if (!found && in_valid[rr_idx]) begin
                    found   = 1'b1;
                    gnt_idx = rr_idx;
                end
            end
        end
        grant = found && load_en && rst_n;
        if (grant) begin
            in_ready[gnt_idx] = 1'b1;
        end
        for (int unsigned i = 0; i < CH; i++) begin
            if (gnt_idx == SW'(i)) begin
                gnt_data = in_data[i*n +: n];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        last_d      = last_q;
        if (grant) begin
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            out_valid_d = 1'b1;
            last_d      = gnt_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            last_q      <= SW'(CH - 1);
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_n_to_1_arb.sv
// Directed bench for mux_n_to_1_arb (n=5, CH=4) with hand-computed expectations.
module tb_mux_n_to_1_arb;

    localparam int unsigned N  = 5;
    localparam int unsigned C  = 4;
    localparam int unsigned S  = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [C*N-1:0]  in_data;
    logic [C-1:0]    in_valid;
    logic [C-1:0]    in_ready;
    logic [S-1:0]    sel;
    logic            mode;
    logic [N-1:0]    out_data;
    logic [S-1:0]    out_ch;
    logic            out_valid;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    mux_n_to_1_arb #(.n(N), .CH(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_rdy [5];
    logic [4:0] rr_dat [5];

    initial begin
        rr_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd1};

        // Reset state, with traffic offered to show in_ready stays low
        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        in_valid  = 4'b1111;
        in_data   = {5'd4, 5'd3, 5'd2, 5'd1};
        out_ready = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data),  0);
        chk("rst_out_ch",    32'(out_ch),    0);
        chk("rst_in_ready",  32'(in_ready),  0);
        tick();
        tick();
        rst_n = 1'b1;

        // Fixed select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data  = {5'd0, 5'd7, 5'd0, 5'd0};
        #1;
        chk("fix_in_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("fix_out_data",  32'(out_data),  7);
        chk("fix_out_ch",    32'(out_ch),    2);
        chk("fix_out_valid", 32'(out_valid), 1);
        in_valid = 4'b0000;
        #1;
        chk("fix_idle_ready", 32'(in_ready), 0);
        tick();
        chk("fix_drain_valid", 32'(out_valid), 0);

        // Round-robin from a fresh reset: channel 0 first, one word per cycle
        rst_n = 1'b0;
        #1;
        rst_n    = 1'b1;
        mode     = 1'b1;
        in_valid = 4'b1111;
        in_data  = {5'd4, 5'd3, 5'd2, 5'd1};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr_in_ready", 32'(in_ready), 32'(rr_rdy[i]));
            tick();
            chk("rr_out_data",  32'(out_data),  32'(rr_dat[i]));
            chk("rr_out_valid", 32'(out_valid), 1);
        end

        // Backpressure: hold 9 for three stalled cycles, then resume
        in_valid = 4'b0001;
        in_data  = {5'd0, 5'd0, 5'd0, 5'd9};
        #1;
        tick();
        chk("bp_load_9", 32'(out_data), 9);
        out_ready = 1'b0;
        in_data   = {5'd0, 5'd0, 5'd0, 5'd5};
        mode      = 1'b0;
        sel       = 2'd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            tick();
            chk("bp_hold_data",  32'(out_data),  9);
            chk("bp_hold_ch",    32'(out_ch),    0);
            chk("bp_hold_valid", 32'(out_valid), 1);
        end
        mode      = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("bp_resume_ready", 32'(in_ready), 32'b0001);
        tick();
        chk("bp_resume_data", 32'(out_data), 5);

        // Wrap and skip: make last=3, then only channels 1 and 2 request
        in_valid = 4'b1000;
        in_data  = {5'd20, 5'd12, 5'd11, 5'd0};
        #1;
        chk("ws_pre_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("ws_pre_ch", 32'(out_ch), 3);
        in_valid = 4'b0110;
        #1;
        chk("ws_g1_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("ws_g1_ch",   32'(out_ch),   1);
        chk("ws_g1_data", 32'(out_data), 11);
        #1;
        chk("ws_g2_ready", 32'(in_ready), 32'b0100);
        tick();
        chk("ws_g2_ch",   32'(out_ch),   2);
        chk("ws_g2_data", 32'(out_data), 12);
        #1;
        chk("ws_g3_ready", 32'(in_ready), 32'b0010);
        tick();
        chk("ws_g3_ch", 32'(out_ch), 1);

        // Fixed select of a channel that is not requesting
        mode     = 1'b0;
        sel      = 2'd3;
        in_valid = 4'b0111;
        #1;
        chk("inv_in_ready", 32'(in_ready), 0);
        tick();
        chk("inv_out_valid", 32'(out_valid), 0);
        chk("inv_keep_ch",   32'(out_ch),    1);

        // Asynchronous reset while a word is held
        mode     = 1'b1;
        in_valid = 4'b0001;
        in_data  = {5'd0, 5'd0, 5'd0, 5'd17};
        tick();
        chk("ar_pre_valid", 32'(out_valid), 1);
        in_valid = 4'b1001;
        rst_n    = 1'b0;
        #1;
        chk("ar_valid_now", 32'(out_valid), 0);
        chk("ar_data_now",  32'(out_data),  0);
        chk("ar_in_ready",  32'(in_ready),  0);
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b1000;
        in_data  = {5'd30, 5'd0, 5'd0, 5'd0};
        #1;
        chk("ar_first_ready", 32'(in_ready), 32'b1000);
        tick();
        chk("ar_first_ch",   32'(out_ch),   3);
        chk("ar_first_data", 32'(out_data), 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_to_1_arb.md
MUX_N_TO_1_ARB -- requirements
Module: mux_n_to_1_arb

Interface
REQ-001 SHALL have parameter n, default 5: data width per channel in bits, n >= 1.
REQ-002 SHALL have parameter CH, default 4: number of input channels, CH >= 2; SW = clog2(CH).
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  CH*n  channel i occupies bits [i*n+n-1 : i*n].
REQ-006 SHALL have port in_valid  input  CH  channel i offers data.
REQ-007 SHALL have port in_ready  output  CH  channel i data accepted this cycle.
REQ-008 SHALL have port sel  input  SW  channel index used in fixed mode.
REQ-009 SHALL have port mode  input  1  0 = fixed select, 1 = round-robin.
REQ-010 SHALL have port out_data  output  n  registered selected data.
REQ-011 SHALL have port out_ch  output  SW  channel index of out_data.
REQ-012 SHALL have port out_valid  output  1  out_data/out_ch hold a valid word.
REQ-013 SHALL have port out_ready  input  1  downstream accepts the word this cycle.

Function
REQ-014 SHALL hold one output word; load_en = !out_valid || out_ready.
REQ-015 SHALL grant at most one channel per cycle, and only when load_en = 1.
REQ-016 Fixed mode: SHALL grant channel sel iff in_valid[sel] = 1 and sel < CH; no grant if sel >= CH.
REQ-017 Round-robin mode: SHALL grant the first channel with in_valid = 1, searching last+1, last+2, ... with wrap from CH-1 to 0, where last is the last granted channel.
REQ-018 SHALL update last to the granted index on every grant, in both modes.
REQ-019 SHALL leave last unchanged in cycles with no grant.
REQ-020 SHALL drive in_ready[g] = 1 combinationally for granted channel g, and 0 for all other channels.
REQ-021 On a grant, SHALL at the next rising edge load out_data from channel g, set out_ch = g and set out_valid = 1. Latency: 1 cycle.
REQ-022 SHALL clear out_valid at the edge where out_valid && out_ready and there is no grant.
REQ-023 SHALL accept a new word and deliver the held word in the same cycle, with no bubble and full throughput.
REQ-024 SHALL keep out_data and out_ch stable while out_valid && !out_ready.
REQ-025 A mode or sel change SHALL affect only the next arbitration; a word already held is not altered.
REQ-026 in_data and in_valid of non-granted channels SHALL have no effect on any register.

Reset
REQ-027 When rst_n = 0, SHALL asynchronously force out_valid = 0, out_data = 0, out_ch = 0 and last = CH-1, so that channel 0 has first priority.
REQ-028 During reset, in_ready SHALL be all zeros.
REQ-029 A held word SHALL be discarded by reset.
REQ-030 The first grant is permitted at the first rising edge after rst_n deasserts.

Verification (n=5, CH=4)
REQ-031 Fixed mode: mode=0, sel=2, in_valid=4'b0100, ch2=7, out_ready=1 -> in_ready=4'b0100; next cycle out_data=7, out_ch=2, out_valid=1.
REQ-032 Round-robin after reset: mode=1, in_valid=4'b1111, channels 0..3 = 1,2,3,4, out_ready=1 -> out_data sequence 1,2,3,4,1 on consecutive cycles, one word per cycle.
REQ-033 Backpressure: out_valid=1 with out_data=9 and out_ready=0 for 3 cycles, in_valid=4'b0001 -> in_ready=0, out_data stays 9; out_ready=1 -> channel 0 granted in that same cycle.
REQ-034 Wrap and skip: last=3, mode=1, in_valid=4'b0110 -> channel 1 granted, then channel 2, then channel 1.
REQ-035 Invalid selection: mode=0, sel=3 with in_valid[3]=0 -> no grant, out_valid falls after the current word is drained.
REQ-036 Reset mid-operation: rst_n=0 while out_valid=1 -> out_valid=0 immediately without a clock edge; after release with mode=1 and in_valid=4'b1000, channel 3 is granted first.
